// File: rtl/key_entry_pkg.sv
// Shared constants, state encoding and key decode helper for the keypad code entry buffer.
package key_entry_pkg;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned KEY_W  = 4;
    localparam int unsigned CODE_W = DIGITS * KEY_W;
    localparam int unsigned CNT_W  = 3;

    localparam logic [KEY_W-1:0] KEY_BKSP  = 4'hB;
    localparam logic [KEY_W-1:0] KEY_CLEAR = 4'hC;
    localparam logic [KEY_W-1:0] KEY_ENTER = 4'hE;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FULL    = 2'd2,
        PRESENT = 2'd3
    } state_e;

    function automatic logic is_digit(input logic [KEY_W-1:0] key);
        return key <= 4'd9;
    endfunction

endpackage

// File: rtl/key_timeout_counter.sv
// Idle-cycle counter for partial entries; expire_c fires when the count reaches TIMEOUT_CYCLES-1.
module key_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic reload,
    input  logic enable,
    output logic expire_c
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [TMR_W-1:0] tmr_q;
    logic [TMR_W-1:0] tmr_d;

    // A reload in the expiring cycle suppresses the expire
    assign expire_c = enable && !reload && (tmr_q == LAST);

    always_comb begin
        tmr_d = tmr_q;
        if (reload || !enable || expire_c) begin
            tmr_d = '0;
        end else begin
            tmr_d = tmr_q + TMR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_d;
        end
    end

endmodule

// File: rtl/key_entry_buffer.sv
// Keypad code entry buffer: collects four digits, presents the code until acknowledged.
// Define KEY_ENTRY_TIMEOUT_EN to compile in the idle timeout that clears partial entries.
module key_entry_buffer
    import key_entry_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic        CLK_KE,
    input  logic        RST_KE,
    input  logic        Key_Valid_KE,
    input  logic [3:0]  Key_Code_KE,
    input  logic        Code_Ack_KE,
    output logic [15:0] Code_KE,
    output logic        Code_Valid_KE,
    output logic [2:0]  Digit_Cnt_KE,
    output logic        Err_KE
);

    // A one-cycle timeout would fire on every idle cycle and has no meaningful counter width
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("key_entry_buffer: TIMEOUT_CYCLES must be at least 2");
    end

    state_e state_q;
    state_e state_d;

    logic [CODE_W-1:0] buf_q;
    logic [CODE_W-1:0] buf_d;
    logic [CODE_W-1:0] code_q;
    logic [CODE_W-1:0] code_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              valid_q;
    logic              valid_d;
    logic              err_q;
    logic              err_d;

    logic is_digit_c;
    logic is_bksp_c;
    logic is_clear_c;
    logic is_enter_c;
    logic key_act_c;
    logic has_room_c;
    logic empty_c;
    logic timeout_c;

    assign is_digit_c = is_digit(Key_Code_KE);
    assign is_bksp_c  = (Key_Code_KE == KEY_BKSP);
    assign is_clear_c = (Key_Code_KE == KEY_CLEAR);
    assign is_enter_c = (Key_Code_KE == KEY_ENTER);
    assign has_room_c = (cnt_q < CNT_W'(DIGITS));
    assign empty_c    = (cnt_q == '0);

    // Recognised keys only count outside PRESENT; they also reload the idle timer
    assign key_act_c = Key_Valid_KE && (state_q != PRESENT) &&
                       (is_digit_c || is_bksp_c || is_clear_c || is_enter_c);

`ifdef KEY_ENTRY_TIMEOUT_EN
    logic tmr_en_c;
    assign tmr_en_c = (state_q == COLLECT) || (state_q == FULL);

    key_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (CLK_KE),
        .rst_n    (RST_KE),
        .reload   (key_act_c),
        .enable   (tmr_en_c),
        .expire_c (timeout_c)
    );
`else
    assign timeout_c = 1'b0;
`endif

    always_ff @(posedge CLK_KE or negedge RST_KE) begin
        if (!RST_KE) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == PRESENT) begin
            if (Code_Ack_KE) begin
                state_d = IDLE;
            end
        end else if (key_act_c) begin
            if (is_digit_c) begin
                if (has_room_c) begin
                    state_d = (cnt_q == CNT_W'(DIGITS - 1)) ? FULL : COLLECT;
                end
            end else if (is_bksp_c) begin
                if (!empty_c) begin
                    state_d = (cnt_q == CNT_W'(1)) ? IDLE : COLLECT;
                end
            end else if (is_clear_c) begin
                state_d = IDLE;
            end else begin
                state_d = (state_q == FULL) ? PRESENT : IDLE;
            end
        end else if (timeout_c) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        buf_d = buf_q;
        cnt_d = cnt_q;
        err_d = 1'b0;
        if (state_q == PRESENT) begin
            if (Code_Ack_KE) begin
                buf_d = '0;
                cnt_d = '0;
            end
        end else if (key_act_c) begin
            if (is_digit_c) begin
                if (has_room_c) begin
                    buf_d = {buf_q[CODE_W-KEY_W-1:0], Key_Code_KE};
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else if (is_bksp_c) begin
                if (!empty_c) begin
                    buf_d = buf_q >> KEY_W;
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end else if (is_clear_c) begin
                buf_d = '0;
                cnt_d = '0;
            end else if (state_q != FULL) begin
                buf_d = '0;
                cnt_d = '0;
                err_d = 1'b1;
            end
        end else if (timeout_c) begin
            buf_d = '0;
            cnt_d = '0;
            err_d = 1'b1;
        end
        // Partial codes never reach the comparator
        code_d  = (state_d == PRESENT) ? buf_d : '0;
        valid_d = (state_d == PRESENT);
    end

    always_ff @(posedge CLK_KE or negedge RST_KE) begin
        if (!RST_KE) begin
            buf_q   <= '0;
            cnt_q   <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign Code_KE       = code_q;
    assign Code_Valid_KE = valid_q;
    assign Digit_Cnt_KE  = cnt_q;
    assign Err_KE        = err_q;

endmodule

// File: tb/tb_key_entry_buffer.sv
// Scoreboard bench for key_entry_buffer: directed scenarios plus random keys against a queue-based model.
module tb_key_entry_buffer;

    localparam int unsigned TO = 16;

    logic        CLK_KE = 1'b0;
    logic        RST_KE = 1'b0;
    logic        Key_Valid_KE = 1'b0;
    logic [3:0]  Key_Code_KE = 4'h0;
    logic        Code_Ack_KE = 1'b0;
    logic [15:0] Code_KE;
    logic        Code_Valid_KE;
    logic [2:0]  Digit_Cnt_KE;
    logic        Err_KE;

    key_entry_buffer #(.TIMEOUT_CYCLES(TO)) dut (
        .CLK_KE        (CLK_KE),
        .RST_KE        (RST_KE),
        .Key_Valid_KE  (Key_Valid_KE),
        .Key_Code_KE   (Key_Code_KE),
        .Code_Ack_KE   (Code_Ack_KE),
        .Code_KE       (Code_KE),
        .Code_Valid_KE (Code_Valid_KE),
        .Digit_Cnt_KE  (Digit_Cnt_KE),
        .Err_KE        (Err_KE)
    );

    always #5 CLK_KE = ~CLK_KE;

    typedef struct {
        bit          is_err;
        logic [15:0] code;
    } ev_t;

    ev_t exp_q[$];
    int  errors = 0;
    int  checks = 0;

    // Model: digits held as a queue, first entered at the front
    int          m_digits[$];
    bit          m_present = 1'b0;
    int          m_timer = 0;
    int          exp_cnt = 0;
    bit          exp_valid = 1'b0;
    bit          exp_err = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endfunction

    function automatic bit recognised(input logic [3:0] k);
        return (k <= 4'd9) || (k == 4'hB) || (k == 4'hC) || (k == 4'hE);
    endfunction

    task automatic model_step(input bit v, input logic [3:0] k, input bit a);
        int code;
        exp_err = 1'b0;
        if (m_present) begin
            if (a) begin
                m_present = 1'b0;
                m_digits.delete();
                m_timer = 0;
            end
        end else if (v && recognised(k)) begin
            m_timer = 0;
            if (k <= 4'd9) begin
                if (m_digits.size() < 4) m_digits.push_back(int'(k));
            end else if (k == 4'hB) begin
                if (m_digits.size() > 0) void'(m_digits.pop_back());
            end else if (k == 4'hC) begin
                m_digits.delete();
            end else if (m_digits.size() == 4) begin
                code = m_digits[0] * 4096 + m_digits[1] * 256 + m_digits[2] * 16 + m_digits[3];
                m_present = 1'b1;
                exp_q.push_back('{is_err: 1'b0, code: 16'(code)});
            end else begin
                exp_err = 1'b1;
                exp_q.push_back('{is_err: 1'b1, code: 16'h0});
                m_digits.delete();
            end
        end else begin
`ifdef KEY_ENTRY_TIMEOUT_EN
            if (m_digits.size() > 0) begin
                m_timer++;
                if (m_timer == int'(TO)) begin
                    exp_err = 1'b1;
                    exp_q.push_back('{is_err: 1'b1, code: 16'h0});
                    m_digits.delete();
                    m_timer = 0;
                end
            end
`endif
        end
        exp_cnt   = m_present ? 4 : m_digits.size();
        exp_valid = m_present;
    endtask

    // Drive one cycle of inputs on the falling edge and advance the model to the next rising edge
    task automatic step(input bit v, input logic [3:0] k, input bit a);
        @(negedge CLK_KE);
        Key_Valid_KE = v;
        Key_Code_KE  = k;
        Code_Ack_KE  = a;
        model_step(v, k, a);
    endtask

    task automatic key(input logic [3:0] k);
        step(1'b1, k, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'h0, 1'b0);
    endtask

    task automatic ack();
        step(1'b0, 4'h0, 1'b1);
    endtask

    task automatic keys(input logic [3:0] ks[$]);
        foreach (ks[i]) key(ks[i]);
    endtask

    // Monitor: per-cycle output checks plus scoreboard pops on Err pulses and code presentations
    initial begin : monitor
        bit          prev_valid = 1'b0;
        logic [15:0] held_code = 16'h0;
        ev_t         ev;
        forever begin
            @(posedge CLK_KE);
            #2;
            check("digit_cnt", 32'(Digit_Cnt_KE), 32'(exp_cnt));
            check("code_valid", 32'(Code_Valid_KE), 32'(exp_valid));
            check("err_pulse", 32'(Err_KE), 32'(exp_err));
            if (!Code_Valid_KE) check("code_zero", 32'(Code_KE), 32'h0);
            if (Err_KE || (Code_Valid_KE && !prev_valid)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: err=%0b code=%0h with empty scoreboard at %0t",
                             Err_KE, Code_KE, $time);
                end else begin
                    ev = exp_q.pop_front();
                    check("event_kind", 32'(Err_KE), 32'(ev.is_err));
                    if (!ev.is_err) begin
                        check("present_code", 32'(Code_KE), 32'(ev.code));
                        held_code = ev.code;
                    end
                end
            end else if (Code_Valid_KE && prev_valid) begin
                check("code_hold", 32'(Code_KE), 32'(held_code));
            end
            prev_valid = Code_Valid_KE;
        end
    end

    initial begin : driver
        int          r;
        bit          v;
        logic [3:0]  k;
        repeat (3) @(negedge CLK_KE);
        RST_KE = 1'b1;

        // Basic entry, present, hold, ack
        keys('{4'h1, 4'h2, 4'h3, 4'h4, 4'hE});
        idle(3);
        ack();
        idle(2);

        // Short entry
        keys('{4'h5, 4'h6, 4'hE});
        idle(2);

        // Backspace at zero, then edit
        keys('{4'hB, 4'h1, 4'h2, 4'h3, 4'hB, 4'h9, 4'h8, 4'hE});
        idle(2);
        ack();
        idle(1);

        // Fifth digit ignored; keys during PRESENT ignored
        keys('{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hE, 4'h7, 4'hC});
        idle(2);
        ack();
        idle(1);

        // Timeout boundary: expire after TO idle cycles, key on the last cycle wins
        key(4'h7);
        idle(TO + 4);
        key(4'h7);
        idle(TO - 1);
        key(4'h8);
        idle(TO - 1);
        key(4'hC);
        idle(2);

        // Asynchronous reset in the middle of PRESENT
        keys('{4'h1, 4'h2, 4'h3, 4'h4, 4'hE});
        idle(2);
        @(negedge CLK_KE);
        #1 RST_KE = 1'b0;
        #1;
        check("async_rst_valid", 32'(Code_Valid_KE), 32'h0);
        check("async_rst_code", 32'(Code_KE), 32'h0);
        check("async_rst_cnt", 32'(Digit_Cnt_KE), 32'h0);
        m_digits.delete();
        m_present = 1'b0;
        m_timer   = 0;
        exp_cnt   = 0;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        #1 RST_KE = 1'b1;
        idle(2);

        // Random traffic including invalid codes, acks outside PRESENT and long idle gaps
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            if (r == 99) begin
                idle(int'(TO) + 2);
            end else begin
                v = (r < 78);
                if (r < 50)      k = 4'($urandom_range(0, 9));
                else if (r < 58) k = 4'hB;
                else if (r < 63) k = 4'hC;
                else if (r < 73) k = 4'hE;
                else if (r % 3 == 0) k = 4'hA;
                else if (r % 3 == 1) k = 4'hD;
                else k = 4'hF;
                step(v, k, ($urandom_range(0, 3) == 0));
            end
        end
        step(1'b0, 4'h0, 1'b1);
        idle(4);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_entry_buffer.md
KEY_ENTRY_BUFFER -- requirements
Module: key_entry_buffer

Interface
- REQ-001: Parameter TIMEOUT_CYCLES, default 1000, is the number of idle cycles during partial entry before an automatic clear.
- REQ-002: Port CLK_KE, input, 1 bit, is the single clock; all flops SHALL update on the rising edge.
- REQ-003: Port RST_KE, input, 1 bit, is the reset; it SHALL be asynchronous and active-low.
- REQ-004: Port Key_Valid_KE, input, 1 bit, is a one-cycle strobe qualifying Key_Code_KE.
- REQ-005: Port Key_Code_KE, input, 4 bits, carries the key: 0x0-0x9 digit, 0xB backspace, 0xC clear, 0xE enter; all other values are ignored.
- REQ-006: Port Code_Ack_KE, input, 1 bit, is the downstream comparator's accept of the presented code.
- REQ-007: Port Code_KE, output, 16 bits, is the assembled code; the first digit entered sits in [15:12].
- REQ-008: Port Code_Valid_KE, output, 1 bit, indicates that Code_KE holds a complete code.
- REQ-009: Port Digit_Cnt_KE, output, 3 bits, is the number of digits held (0-4).
- REQ-010: Port Err_KE, output, 1 bit, is a one-cycle pulse flagging a short entry or a timeout.

Function
- REQ-011: The FSM SHALL have four states: IDLE (cnt=0), COLLECT (cnt 1-3), FULL (cnt=4) and PRESENT.
- REQ-012: A digit accepted in IDLE or COLLECT SHALL shift the buffer left 4 bits, insert the digit at [3:0], and increment cnt; the state follows cnt.
- REQ-013: A digit accepted in FULL SHALL be ignored, with no overwrite and no Err.
- REQ-014: Backspace SHALL shift the buffer right 4 bits and decrement cnt; backspace at cnt=0 SHALL be ignored.
- REQ-015: Clear in IDLE, COLLECT or FULL SHALL zero the buffer and cnt and return the FSM to IDLE.
- REQ-016: Enter in FULL SHALL move to PRESENT; Code_Valid_KE SHALL be high in the cycle after the Enter strobe (latency 1).
- REQ-017: Enter with cnt<4 SHALL pulse Err_KE for one cycle, clear the buffer and go to IDLE.
- REQ-018: In PRESENT, Code_Valid_KE and Code_KE SHALL stay stable until Code_Ack_KE is sampled high; in the next cycle Code_Valid_KE=0, the buffer is cleared and the FSM is in IDLE.
- REQ-019: All keys, including clear, SHALL be ignored in PRESENT; Code_Ack_KE SHALL be ignored outside PRESENT.
- REQ-020: Code_KE SHALL read 0x0000 in every state except PRESENT, so partial codes never reach the comparator.
- REQ-021: The timeout counter SHALL run only in COLLECT and FULL and SHALL reload to 0 on every accepted key.
- REQ-022: When the timeout counter reaches TIMEOUT_CYCLES-1, the block SHALL clear the buffer, go to IDLE and pulse Err_KE.
- REQ-023: If a key arrives in the same cycle the timeout would fire, the key SHALL win and the counter SHALL reload.
- REQ-024: The timeout counter width SHALL be $clog2(TIMEOUT_CYCLES).

Reset
- REQ-025: While RST_KE=0, the outputs SHALL be Code_KE=0, Code_Valid_KE=0, Digit_Cnt_KE=0 and Err_KE=0, the FSM SHALL be in IDLE, and the buffer and timer SHALL be 0, asynchronously and in any state, including mid-PRESENT.

Configuration
- REQ-026: Macro KEY_ENTRY_TIMEOUT_EN, when defined, SHALL compile in the timeout counter of REQ-021 to REQ-024.
- REQ-027: When KEY_ENTRY_TIMEOUT_EN is undefined, no timer SHALL exist, partial entries SHALL be held indefinitely, and Err_KE SHALL come only from a short Enter.

Structure
- REQ-028: Package key_entry_pkg SHALL hold KEY_BKSP=4'hB, KEY_CLEAR=4'hC, KEY_ENTER=4'hE, DIGITS=4 and the FSM state enum.
- REQ-029: Sub-module key_timeout_counter (reload, enable, expire pulse) SHALL be instantiated only under KEY_ENTRY_TIMEOUT_EN.

Verification
- REQ-030: Keys 1,2,3,4,Enter -> next cycle Code_Valid_KE=1, Code_KE=0x1234, and Code_KE held; Ack -> next cycle Code_Valid_KE=0, Code_KE=0, Digit_Cnt_KE=0.
- REQ-031: Keys 5,6,Enter -> single-cycle Err_KE, Code_Valid_KE stays 0, Digit_Cnt_KE=0.
- REQ-032: Keys 1,2,3,Bksp,9,8,Enter -> Code_KE=0x1298; Bksp at cnt=0 leaves Digit_Cnt_KE=0.
- REQ-033: Keys 1,2,3,4,5,Enter -> Code_KE=0x1234; keys 7 and Clear during PRESENT leave Code_KE=0x1234 and Code_Valid_KE=1 until Ack.
- REQ-034: With TIMEOUT_CYCLES=16 and the macro defined, key 7 then 16 idle cycles -> Err_KE pulse and Digit_Cnt_KE=0; a key on cycle 15 -> no Err; with the macro undefined, Digit_Cnt_KE stays 1 indefinitely.
- REQ-035: RST_KE driven low mid-PRESENT (Code_KE=0x1234) -> Code_Valid_KE=0 and Code_KE=0 immediately, without waiting for a clock edge.
